keypad_scanner: RTL and testbench

//   Drives a 4x3 matrix keypad and turns it into the clean per-key levels that level_select consumes on its keypad_N inputs.

---
 rtl/keypad_pkg.sv | 34 +++
 rtl/keypad_debounce.sv | 104 ++++++++++
 rtl/keypad_scanner.sv | 80 ++++++++
 tb/tb_keypad_scanner.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x3 keypad scanner: matrix geometry, special key
// codes, debounce FSM states and the frame-bit to key-code map.
package keypad_pkg;

    localparam int N_ROWS = 4;
    localparam int N_COLS = 3;
    localparam int N_KEYS = N_ROWS * N_COLS;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        MULTI   = 2'd2
    } state_t;

    // Frame bit index is row*3+col; rows read 1 2 3 / 4 5 6 / 7 8 9 / * 0 #.
    function automatic logic [3:0] key_code_of(input logic [3:0] idx);
        logic [3:0] code;
        code = 4'd0;
        if (idx <= 4'd8) begin
            code = idx + 4'd1;
        end else if (idx == 4'd9) begin
            code = KEY_STAR;
        end else if (idx == 4'd10) begin
            code = 4'd0;
        end else if (idx == 4'd11) begin
            code = KEY_HASH;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce and key-state FSM: compares successive matrix frames,
// commits a frame once it has been stable long enough, and publishes key levels.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_valid,
    input  logic [N_KEYS-1:0] frame,
    output logic [N_KEYS-1:0] keypad,
    output logic [3:0]        key_code,
    output logic              key_valid,
    output state_t            state
);

    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(DEBOUNCE_FRAMES - 1);

    logic [N_KEYS-1:0] prev_frame;
    logic [N_KEYS-1:0] committed;
    logic [CNT_W-1:0]  stable_cnt;

    logic [CNT_W-1:0]  stable_next;
    logic              commit;
    logic [3:0]        pop;
    logic [3:0]        key_idx;
    logic [3:0]        code;

    state_t            state_next;
    logic [N_KEYS-1:0] keypad_next;
    logic [3:0]        key_code_next;
    logic              key_valid_next;
    logic [N_KEYS-1:0] committed_next;

    always_comb begin
        stable_next = '0;
        if (frame == prev_frame) begin
            stable_next = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + 1'b1;
        end
        commit = frame_valid && (stable_next >= CNT_COMMIT) && (frame != committed);
    end

    // A committed single-key frame has exactly one bit set, so the last set bit is the key.
    always_comb begin
        pop     = 4'd0;
        key_idx = 4'd0;
        for (int i = 0; i < N_KEYS; i++) begin
            pop = pop + 4'(frame[i]);
            if (frame[i]) begin
                key_idx = 4'(i);
            end
        end
        code = key_code_of(key_idx);
    end

    always_comb begin
        state_next     = state;
        keypad_next    = keypad;
        key_code_next  = key_code;
        key_valid_next = 1'b0;
        committed_next = committed;
        if (commit) begin
            committed_next = frame;
            if (pop == 4'd0) begin
                state_next  = IDLE;
                keypad_next = '0;
            end else if (pop == 4'd1) begin
                state_next     = PRESSED;
                keypad_next    = N_KEYS'(1) << code;
                key_code_next  = code;
                key_valid_next = (state == IDLE);
            end else begin
                state_next  = MULTI;
                keypad_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_frame <= '0;
            committed  <= '0;
            stable_cnt <= '0;
            state      <= IDLE;
            keypad     <= '0;
            key_code   <= 4'd0;
            key_valid  <= 1'b0;
        end else begin
            if (frame_valid) begin
                prev_frame <= frame;
                stable_cnt <= stable_next;
            end
            committed <= committed_next;
            state     <= state_next;
            keypad    <= keypad_next;
            key_code  <= key_code_next;
            key_valid <= key_valid_next;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: drives rows in turn, synchronises the columns,
// assembles whole-matrix frames and hands them to the debounce/FSM stage.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_COLS-1:0] col_in,
    output logic [N_ROWS-1:0] row_out,
    output logic [N_KEYS-1:0] keypad,
    output logic [3:0]        key_code,
    output logic              key_valid,
    output logic              multi_key
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [N_COLS-1:0] col_meta;
    logic [N_COLS-1:0] col_sync;
    logic [DIV_W-1:0]  div_cnt;
    logic [1:0]        row_idx;
    logic [3:0]        row_base;
    logic [N_KEYS-1:0] raw_frame;
    logic [N_KEYS-1:0] frame;
    logic              frame_valid;
    logic              sample;
    state_t            fsm_state;

    assign sample   = (div_cnt == DIV_LAST);
    assign row_base = {1'b0, row_idx, 1'b0} + {2'b00, row_idx};
    assign row_out  = ~(N_ROWS'(1) << row_idx);

    // Sampling at the end of each row slot gives the row drive time to settle through the synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta    <= '1;
            col_sync    <= '1;
            div_cnt     <= '0;
            row_idx     <= 2'd0;
            raw_frame   <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
        end else begin
            col_meta    <= col_in;
            col_sync    <= col_meta;
            frame_valid <= 1'b0;
            if (sample) begin
                div_cnt                        <= '0;
                row_idx                        <= row_idx + 2'd1;
                raw_frame[row_base +: N_COLS]  <= ~col_sync;
                if (row_idx == 2'd3) begin
                    frame       <= {~col_sync, raw_frame[N_KEYS-N_COLS-1:0]};
                    frame_valid <= 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .frame_valid(frame_valid),
        .frame      (frame),
        .keypad     (keypad),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .state      (fsm_state)
    );

    assign multi_key = (fsm_state == MULTI);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=2 (16-cycle frames)
// and a behavioural 4x3 matrix pulling columns low on driven rows.
module tb_keypad_scanner;

    localparam int HOLD = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  col_in;
    logic [3:0]  row_out;
    logic [11:0] keypad;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        multi_key;

    logic [11:0] pressed = '0;
    int          checks = 0;
    int          errors = 0;
    int          valid_cnt = 0;
    logic        seen_keypad = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_FRAMES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .col_in   (col_in),
        .row_out  (row_out),
        .keypad   (keypad),
        .key_code (key_code),
        .key_valid(key_valid),
        .multi_key(multi_key)
    );

    always_comb begin
        col_in = 3'b111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!row_out[r] && pressed[r*3+c]) col_in[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (key_valid) valid_cnt++;
        if (keypad != 12'h000) seen_keypad = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        string       name;
        logic [11:0] press;
        logic [11:0] exp_keypad;
        logic [3:0]  exp_code;
        logic        exp_multi;
        int          exp_valid;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [3:0] exp_row;
        logic [3:0] r0;
        logic       found;

        vecs[0]  = '{"press_1",      12'h001, 12'h002, 4'd1,  1'b0, 1};
        vecs[1]  = '{"release_1",    12'h000, 12'h000, 4'd1,  1'b0, 0};
        vecs[2]  = '{"multi_2_3",    12'h006, 12'h000, 4'd1,  1'b1, 0};
        vecs[3]  = '{"drop_3",       12'h002, 12'h004, 4'd2,  1'b0, 0};
        vecs[4]  = '{"release_2",    12'h000, 12'h000, 4'd2,  1'b0, 0};
        vecs[5]  = '{"press_hash",   12'h800, 12'h800, 4'd11, 1'b0, 1};
        vecs[6]  = '{"roll_star",    12'h200, 12'h400, 4'd10, 1'b0, 0};
        vecs[7]  = '{"release_star", 12'h000, 12'h000, 4'd10, 1'b0, 0};
        vecs[8]  = '{"press_9",      12'h100, 12'h200, 4'd9,  1'b0, 1};
        vecs[9]  = '{"multi_9_7",    12'h140, 12'h000, 4'd9,  1'b1, 0};
        vecs[10] = '{"release_97",   12'h000, 12'h000, 4'd9,  1'b0, 0};
        vecs[11] = '{"press_6",      12'h020, 12'h040, 4'd6,  1'b0, 1};
        vecs[12] = '{"release_6",    12'h000, 12'h000, 4'd6,  1'b0, 0};

        // Reset and row rotation
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_keypad", 32'(keypad), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_multi", 32'(multi_key), 32'h0);
        for (int k = 0; k < 16; k++) begin
            exp_row = ~(4'b0001 << (k / 4));
            check($sformatf("row_out_k%0d", k), 32'(row_out), 32'(exp_row));
            step();
        end

        // Table-driven key sequences
        for (int v = 0; v < 13; v++) begin
            pressed   = vecs[v].press;
            valid_cnt = 0;
            run(HOLD);
            check({vecs[v].name, "_keypad"}, 32'(keypad), 32'(vecs[v].exp_keypad));
            check({vecs[v].name, "_code"}, 32'(key_code), 32'(vecs[v].exp_code));
            check({vecs[v].name, "_multi"}, 32'(multi_key), 32'(vecs[v].exp_multi));
            check({vecs[v].name, "_valids"}, 32'(valid_cnt), 32'(vecs[v].exp_valid));
        end

        // '0' pressed 7 cycles after a row edge; must commit within 3 frames
        r0 = row_out;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            if (row_out != r0) found = 1'b1;
        end
        check("zero_row_edge", 32'(found), 32'h1);
        run(7);
        pressed   = 12'h400;
        valid_cnt = 0;
        found     = 1'b0;
        for (int i = 0; i < 52 && !found; i++) begin
            step();
            if (valid_cnt != 0) found = 1'b1;
        end
        check("zero_latency", 32'(found), 32'h1);
        run(HOLD);
        check("zero_keypad", 32'(keypad), 32'h001);
        check("zero_code", 32'(key_code), 32'h0);
        check("zero_valids", 32'(valid_cnt), 32'h1);
        pressed = '0;
        run(HOLD);
        check("zero_release", 32'(keypad), 32'h0);

        // Bounce '5' aligned to a frame start, then hold
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (row_out == 4'b0111) found = 1'b1;
        end
        check("bounce_sync_row3", 32'(found), 32'h1);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            if (row_out == 4'b1110) found = 1'b1;
        end
        check("bounce_sync_row0", 32'(found), 32'h1);
        valid_cnt   = 0;
        seen_keypad = 1'b0;
        for (int t = 0; t < 40; t++) begin
            pressed[4] = ((t / 3) % 2 == 0);
            step();
        end
        check("bounce_no_valid", 32'(valid_cnt), 32'h0);
        check("bounce_no_keypad", 32'(seen_keypad), 32'h0);
        pressed[4] = 1'b1;
        run(HOLD);
        check("bounce_keypad", 32'(keypad), 32'h020);
        check("bounce_code", 32'(key_code), 32'h5);
        check("bounce_valids", 32'(valid_cnt), 32'h1);
        pressed = '0;
        run(HOLD);
        check("bounce_release", 32'(keypad), 32'h0);

        // Hold '#' across a one-cycle mid-frame reset
        pressed   = 12'h800;
        valid_cnt = 0;
        run(HOLD);
        check("hash_keypad", 32'(keypad), 32'h800);
        check("hash_valids", 32'(valid_cnt), 32'h1);
        run(5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_keypad", 32'(keypad), 32'h0);
        check("midrst_code", 32'(key_code), 32'h0);
        check("midrst_valid", 32'(key_valid), 32'h0);
        check("midrst_multi", 32'(multi_key), 32'h0);
        check("midrst_row", 32'(row_out), 32'hE);
        valid_cnt = 0;
        run(HOLD);
        check("redetect_keypad", 32'(keypad), 32'h800);
        check("redetect_code", 32'(key_code), 32'd11);
        check("redetect_valids", 32'(valid_cnt), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
